// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipeline: drives PC and inter-stage
// register enables/clears, tracks multiply latency and stale fetches.
module pipe_hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             icache_ready,
   input  logic             load_use_hazard,
   input  logic             ex_is_mul,
   input  logic             branch_taken_e,
   input  logic             dcache_req,
   input  logic             dcache_ready,
   output logic             pc_en,
   output logic             fd_en,
   output logic             de_en,
   output logic             em_en,
   output logic             mw_en,
   output logic             fd_flush,
   output logic             de_flush,
   output logic             em_flush,
   output logic             mw_flush,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam bit MUL_EN = (MUL_LAT > 1);
   localparam int MC_W   = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
   localparam logic [MC_W-1:0] MUL_LOAD = MUL_EN ? MC_W'(MUL_LAT - 2) : '0;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_BUSY = 2'd1,
      M_DONE = 2'd2
   } mul_state_t;

   mul_state_t       mul_state_q, mul_state_d;
   logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
   logic             discard_q, discard_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic dstall, mstall;

   assign dstall = dcache_req & ~dcache_ready;
   assign mstall = MUL_EN & ex_is_mul & (mul_state_q != M_DONE);

   // Oldest-stage-first resolution; only the first matching condition applies.
   always_comb begin
      pc_en     = 1'b1;
      fd_en     = 1'b1;
      de_en     = 1'b1;
      em_en     = 1'b1;
      mw_en     = 1'b1;
      fd_flush  = 1'b0;
      de_flush  = 1'b0;
      em_flush  = 1'b0;
      mw_flush  = 1'b0;
      discard_d = discard_q;
      if (reset) begin
         pc_en    = 1'b0;
         fd_en    = 1'b0;
         de_en    = 1'b0;
         em_en    = 1'b0;
         mw_en    = 1'b0;
         fd_flush = 1'b1;
         de_flush = 1'b1;
         em_flush = 1'b1;
         mw_flush = 1'b1;
      end else if (dstall) begin
         pc_en    = 1'b0;
         fd_en    = 1'b0;
         de_en    = 1'b0;
         em_en    = 1'b0;
         mw_flush = 1'b1;
      end else if (mstall) begin
         pc_en    = 1'b0;
         fd_en    = 1'b0;
         de_en    = 1'b0;
         em_flush = 1'b1;
      end else if (branch_taken_e) begin
         fd_flush = 1'b1;
         de_flush = 1'b1;
         // The fetch in flight targets the wrong path; drop it when it lands.
         if (!icache_ready) discard_d = 1'b1;
      end else if (load_use_hazard) begin
         pc_en    = 1'b0;
         fd_en    = 1'b0;
         de_flush = 1'b1;
      end else if (icache_ready && discard_q) begin
         pc_en     = 1'b0;
         fd_flush  = 1'b1;
         discard_d = 1'b0;
      end else if (!icache_ready) begin
         pc_en    = 1'b0;
         fd_flush = 1'b1;
      end
   end

   // mul_cnt_q holds the stall cycles still owed including the current one.
   always_comb begin
      mul_state_d = mul_state_q;
      mul_cnt_d   = mul_cnt_q;
      case (mul_state_q)
         M_IDLE: begin
            if (MUL_EN && ex_is_mul && !dstall) begin
               mul_cnt_d   = MUL_LOAD;
               mul_state_d = (MUL_LOAD == '0) ? M_DONE : M_BUSY;
            end
         end
         M_BUSY: begin
            if (!dstall) begin
               mul_cnt_d = mul_cnt_q - 1'b1;
               if (mul_cnt_q <= MC_W'(1)) mul_state_d = M_DONE;
            end
         end
         M_DONE: begin
            if (em_en && !dstall) mul_state_d = M_IDLE;
         end
         default: mul_state_d = M_IDLE;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mul_state_q <= M_IDLE;
         mul_cnt_q   <= '0;
         discard_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         mul_state_q <= mul_state_d;
         mul_cnt_q   <= mul_cnt_d;
         discard_q   <= discard_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (F, D, E, M, W).
- Drives the enable and synchronous-clear inputs of the PC register and the four inter-stage pipeline registers: fd, de, em, mw.
- Resolves data-cache misses, multi-cycle multiply, load-use hazards, instruction-cache misses and taken-branch redirects, with a fixed oldest-stage-first priority.
- Tracks multiply latency and stale fetches internally, and exposes a stall-cycle performance counter.

Parameters:
- MUL_LAT, 4, multiply latency in cycles (>=1); E stalls MUL_LAT-1 cycles per multiply.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- icache_ready  input  1  fetch data valid this cycle.
- load_use_hazard  input  1  D needs the result of a load currently in E.
- ex_is_mul  input  1  E holds a multiply.
- branch_taken_e  input  1  E resolved a taken branch/jump; never high together with ex_is_mul.
- dcache_req  input  1  M holds a load/store.
- dcache_ready  input  1  data-cache access completes this cycle.
- pc_en  output  1  PC register enable.
- fd_en, de_en, em_en, mw_en  output  1 each  pipeline register enables.
- fd_flush, de_flush, em_flush, mw_flush  output  1 each  pipeline register clear (bubble insert); flush dominates enable.
- stall_cycles  output  CNT_W  count of cycles with pc_en=0.

Behaviour:
- All enable/flush outputs are combinational from inputs and state.
- While reset is high: all enables 0, all flushes 1, stall_cycles=0, mul FSM=M_IDLE, discard_q=0.
- Conditions are evaluated in priority order; the first true condition applies. Unlisted enables are 1 and unlisted flushes are 0.
  1. dstall = dcache_req & ~dcache_ready: pc/fd/de/em en=0, mw_flush=1.
  2. mstall = ex_is_mul & mul_state!=M_DONE & MUL_LAT>1: pc/fd/de en=0, em_flush=1.
  3. redirect = branch_taken_e: pc_en=1, fd_flush=1, de_flush=1. If ~icache_ready, set discard_q at the clock edge.
  4. load_use_hazard: pc_en=0, fd_en=0, de_flush=1.
  5. discard = icache_ready & discard_q: pc_en=0, fd_flush=1; clear discard_q.
  6. ~icache_ready: pc_en=0, fd_flush=1.
  7. Otherwise: all enables 1, no flush.
- A redirect suppressed by dstall is not recorded; the branch stays in E and re-asserts branch_taken_e.
- discard_q persists across higher-priority stalls until the stale response arrives.
- Mul FSM states: M_IDLE, M_BUSY, M_DONE.
  - M_IDLE & ex_is_mul & MUL_LAT>1 & ~dstall -> M_BUSY, cnt=MUL_LAT-2.
  - M_BUSY: if ~dstall, cnt decrements; at cnt==0 -> M_DONE. cnt freezes during dstall.
  - M_DONE & em_en & ~dstall -> M_IDLE.
  - MUL_LAT=1: FSM stays in M_IDLE and produces no stall.
- Back-to-back multiplies each pay the full MUL_LAT-1 stall.
- stall_cycles increments by 1 each cycle pc_en=0, saturates at all-ones, and never wraps.

Test Plan:
- Reset mid-operation: assert reset during M_BUSY with discard_q=1 -> outputs go immediately to enables 0 / flushes 1; after release, state is M_IDLE, discard_q=0, stall_cycles=0.
- MUL_LAT=4, ex_is_mul held for a single multiply -> exactly 3 cycles of pc/fd/de en=0 with em_flush=1, then 1 advance cycle; stall_cycles += 3.
- dcache_req=1 with dcache_ready low for 5 cycles, coincident with ex_is_mul -> 5 cycles of mw_flush=1 with em_en=0; mul count frozen; after ready, 3 further mul-stall cycles.
- branch_taken_e while icache_ready=0 -> pc_en=1, fd_flush=de_flush=1 that cycle; 2 cycles later icache_ready=1 -> fd_flush=1, pc_en=0 (discarded); the next icache_ready cycle is a normal fetch.
- load_use_hazard and branch_taken_e both high -> redirect wins (de_flush=1, pc_en=1); load_use_hazard alone -> pc_en=0, fd_en=0, de_flush=1, em_en=1.
- Saturation: CNT_W=4 with icache_ready low for 20 cycles -> stall_cycles reaches 15 and holds at 15.
